nametable_write_scheduler: RTL and testbench

Sequences all writes into the PPU name table. It decodes CPU memory-mapped writes to the video registers and buffers single-byte writes in a small FIFO with an auto-incrementing pointer. It also runs a RAM-to-name-table copy (DMA) engine that requests the RAM read port from the top-level arbiter. It is the only driver of the PPU nameTableWrite* port and sits between the CPU RAM-write bus and the PPU.

---
 rtl/nametable_sched_pkg.sv | 23 ++
 rtl/nametable_write_scheduler_if.sv | 31 +++
 rtl/sync_fifo.sv | 45 ++++
 rtl/nametable_write_scheduler.sv | 154 +++++++++++++++
 tb/tb_nametable_write_scheduler.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nametable_sched_pkg.sv
// Shared definitions for the name-table write scheduler: MMIO map, FSM states
// and the buffered byte-write entry format.
package nametable_sched_pkg;

  localparam logic [15:0] NT_PTR_DATA = 16'hFFFF;
  localparam logic [15:0] NT_DMA_SRC  = 16'hFFFE;
  localparam logic [15:0] NT_DMA_LEN  = 16'hFFFD;

  localparam int unsigned NT_ADDR_W = 13;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    REQ,
    XFER
  } schedState_t;

  typedef struct packed {
    logic [NT_ADDR_W-1:0] addr;
    logic [7:0]           data;
  } ntEntry_t;

endpackage

// File: rtl/nametable_write_scheduler_if.sv
// CPU write bus, RAM read port and PPU name-table write port of the scheduler.
// master = scheduler side, slave = surrounding system side.
interface nametable_write_scheduler_if #(
  parameter int unsigned NtAddrWidth = 13
);
  logic                   cpuWriteEnable;
  logic [15:0]            cpuWriteAddr;
  logic [15:0]            cpuWriteData;
  logic                   dmaReadReq;
  logic [15:0]            dmaReadAddr;
  logic                   dmaReadGrant;
  logic [15:0]            ramReadData;
  logic                   nameTableWriteEnable;
  logic [NtAddrWidth-1:0] nameTableWriteAddr;
  logic [7:0]             nameTableWriteData;
  logic                   busy;
  logic                   fifoOverflow;
  logic                   cmdError;

  modport master (
    input  cpuWriteEnable, cpuWriteAddr, cpuWriteData, dmaReadGrant, ramReadData,
    output dmaReadReq, dmaReadAddr, nameTableWriteEnable, nameTableWriteAddr,
           nameTableWriteData, busy, fifoOverflow, cmdError
  );

  modport slave (
    output cpuWriteEnable, cpuWriteAddr, cpuWriteData, dmaReadGrant, ramReadData,
    input  dmaReadReq, dmaReadAddr, nameTableWriteEnable, nameTableWriteAddr,
           nameTableWriteData, busy, fifoOverflow, cmdError
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   push,
  input  logic [Width-1:0]       pushData,
  input  logic                   pop,
  output logic [Width-1:0]       popData,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);
  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AddrW-1:0] wrPtr, rdPtr;
  logic             doPush, doPop;

  assign empty   = (count == '0);
  assign full    = (count == (AddrW + 1)'(Depth));
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop)      count <= count + 1'b1;
      else if (doPop && !doPush) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/nametable_write_scheduler.sv
// Sole driver of the PPU name-table write port: decodes CPU MMIO writes, buffers
// byte writes in a FIFO and runs the RAM-to-name-table copy engine.
module nametable_write_scheduler
  import nametable_sched_pkg::*;
#(
  parameter int unsigned FifoDepth   = 4,
  parameter int unsigned NtAddrWidth = 13
) (
  input logic                         clk,
  input logic                         rstN,
  nametable_write_scheduler_if.master bus
);
  localparam int unsigned CntW = $clog2(FifoDepth) + 1;

  schedState_t            state;
  logic [NtAddrWidth-1:0] ptr, dmaDst, dmaCount;
  logic [15:0]            dmaSrc;
  logic [CntW-1:0]        drainLeft;

  logic                   wrEn, reqQ, ovfQ, errQ;
  logic [NtAddrWidth-1:0] wrAddr;
  logic [7:0]             wrData;
  logic [15:0]            rdAddr;

  logic                   isPtrData, setPtr, byteWr, setSrc, lenWr, startReq, dmaStart;
  logic [NtAddrWidth-1:0] dmaLen;

  ntEntry_t                  pushEntry, headEntry;
  logic [$bits(ntEntry_t)-1:0] headBits;
  logic                      fifoPop, fifoFull, fifoEmpty;
  logic [CntW-1:0]           fifoCount;

  assign isPtrData = bus.cpuWriteEnable && (bus.cpuWriteAddr == NT_PTR_DATA);
  assign setPtr    = isPtrData && bus.cpuWriteData[15];
  assign byteWr    = isPtrData && !bus.cpuWriteData[15];
  assign setSrc    = bus.cpuWriteEnable && (bus.cpuWriteAddr == NT_DMA_SRC);
  assign lenWr     = bus.cpuWriteEnable && (bus.cpuWriteAddr == NT_DMA_LEN);
  assign dmaLen    = bus.cpuWriteData[NtAddrWidth-1:0];
  assign startReq  = lenWr && (dmaLen != '0);
  assign dmaStart  = startReq && (state == IDLE);

  assign pushEntry = '{addr: NT_ADDR_W'(ptr), data: bus.cpuWriteData[7:0]};
  assign headEntry = ntEntry_t'(headBits);

  // DRAIN only pops the entries that were queued before the DMA start.
  always_comb begin
    fifoPop = 1'b0;
    unique case (state)
      IDLE:    fifoPop = !fifoEmpty;
      DRAIN:   fifoPop = (drainLeft != '0);
      default: fifoPop = 1'b0;
    endcase
  end

  sync_fifo #(
    .Width ($bits(ntEntry_t)),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk      (clk),
    .rstN     (rstN),
    .push     (byteWr),
    .pushData (pushEntry),
    .pop      (fifoPop),
    .popData  (headBits),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      ptr       <= '0;
      dmaSrc    <= '0;
      dmaDst    <= '0;
      dmaCount  <= '0;
      drainLeft <= '0;
      wrEn      <= 1'b0;
      wrAddr    <= '0;
      wrData    <= '0;
      reqQ      <= 1'b0;
      rdAddr    <= '0;
      ovfQ      <= 1'b0;
      errQ      <= 1'b0;
    end else begin
      wrEn <= 1'b0;
      if (byteWr && fifoFull && !fifoPop) ovfQ <= 1'b1;
      if (startReq && (state != IDLE))    errQ <= 1'b1;

      if (setPtr)        ptr <= bus.cpuWriteData[NtAddrWidth-1:0];
      else if (byteWr)   ptr <= ptr + 1'b1;
      else if (dmaStart) ptr <= ptr + dmaLen;

      if (fifoPop) begin
        wrEn   <= 1'b1;
        wrAddr <= NtAddrWidth'(headEntry.addr);
        wrData <= headEntry.data;
      end

      unique case (state)
        IDLE: begin
          if (dmaStart) begin
            dmaDst    <= ptr;
            dmaCount  <= dmaLen;
            drainLeft <= fifoCount - CntW'(fifoPop);
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drainLeft == '0) begin
            reqQ   <= 1'b1;
            rdAddr <= dmaSrc;
            state  <= REQ;
          end else begin
            drainLeft <= drainLeft - 1'b1;
          end
        end
        REQ: begin
          if (bus.dmaReadGrant) begin
            reqQ  <= 1'b0;
            state <= XFER;
          end
        end
        XFER: begin
          wrEn     <= 1'b1;
          wrAddr   <= dmaDst;
          wrData   <= bus.ramReadData[7:0];
          dmaDst   <= dmaDst + 1'b1;
          dmaSrc   <= dmaSrc + 1'b1;
          dmaCount <= dmaCount - 1'b1;
          if (dmaCount == NtAddrWidth'(1)) begin
            state <= IDLE;
          end else begin
            reqQ   <= 1'b1;
            rdAddr <= dmaSrc + 1'b1;
            state  <= REQ;
          end
        end
        default: state <= IDLE;
      endcase

      if (setSrc) dmaSrc <= bus.cpuWriteData;
    end
  end

  assign bus.nameTableWriteEnable = wrEn;
  assign bus.nameTableWriteAddr   = wrAddr;
  assign bus.nameTableWriteData   = wrData;
  assign bus.dmaReadReq           = reqQ;
  assign bus.dmaReadAddr          = rdAddr;
  assign bus.fifoOverflow         = ovfQ;
  assign bus.cmdError             = errQ;
  assign bus.busy                 = !fifoEmpty || (state != IDLE) || wrEn;
endmodule

// File: tb/tb_nametable_write_scheduler.sv
// Self-checking bench: the reference model tracks the expected name-table write
// stream in CPU program order and compares it with the writes the DUT emits.
module tb_nametable_write_scheduler;
  import nametable_sched_pkg::*;

  localparam int FIFO_DEPTH = 4;

  typedef struct {
    logic [12:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   grantMode = 0;
  int   reqCount = 0;

  nametable_write_scheduler_if #(.NtAddrWidth(13)) bus ();

  nametable_write_scheduler #(
    .FifoDepth   (FIFO_DEPTH),
    .NtAddrWidth (13)
  ) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  logic [15:0] ram [65536];
  wr_t         obsQ[$];
  wr_t         expQ[$];
  int          lastCycs[$];

  logic [12:0] mPtr = '0;
  logic [15:0] mSrc = '0;
  logic        mOvf = 1'b0;
  logic        mCmdErr = 1'b0;
  logic        mPending = 1'b0;
  int          mQueued = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    case (grantMode)
      0:       bus.dmaReadGrant = 1'b0;
      1:       bus.dmaReadGrant = 1'b1;
      default: bus.dmaReadGrant = 1'($urandom_range(0, 1));
    endcase
  end

  // RAM read port: data valid the cycle after a granted request, junk otherwise.
  always @(posedge clk) begin
    if (bus.dmaReadReq && bus.dmaReadGrant) bus.ramReadData <= ram[bus.dmaReadAddr];
    else                                    bus.ramReadData <= 16'hDEAD;
  end

  always @(negedge clk) begin
    if (bus.nameTableWriteEnable) begin
      wr_t w;
      w.addr = bus.nameTableWriteAddr;
      w.data = bus.nameTableWriteData;
      w.cyc  = cyc;
      obsQ.push_back(w);
    end
    if (bus.dmaReadReq) reqCount++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cpuWr(input logic [15:0] a, input logic [15:0] d);
    bus.cpuWriteEnable = 1'b1;
    bus.cpuWriteAddr   = a;
    bus.cpuWriteData   = d;
    @(negedge clk);
    bus.cpuWriteEnable = 1'b0;
  endtask

  task automatic opPtr(input logic [12:0] a);
    cpuWr(NT_PTR_DATA, {1'b1, 2'($urandom), a});
    mPtr = a;
  endtask

  task automatic opByte(input logic [7:0] d);
    wr_t w;
    cpuWr(NT_PTR_DATA, {1'b0, 7'($urandom), d});
    if (mPending && mQueued >= FIFO_DEPTH) begin
      mOvf = 1'b1;
    end else begin
      w.addr = mPtr; w.data = d; w.cyc = 0;
      expQ.push_back(w);
      if (mPending) mQueued++;
    end
    mPtr = mPtr + 13'd1;
  endtask

  task automatic opSrc(input logic [15:0] s);
    cpuWr(NT_DMA_SRC, s);
    mSrc = s;
  endtask

  task automatic opLen(input logic [12:0] len, input logic [2:0] upper);
    wr_t         w;
    logic [15:0] s;
    cpuWr(NT_DMA_LEN, {upper, len});
    if (len == 13'd0) begin
    end else if (mPending) begin
      mCmdErr = 1'b1;
    end else begin
      for (int i = 0; i < int'(len); i++) begin
        s      = mSrc + 16'(i);
        w.addr = mPtr + 13'(i);
        w.data = ram[s][7:0];
        w.cyc  = 0;
        expQ.push_back(w);
      end
      mPtr     = mPtr + len;
      mSrc     = mSrc + 16'(len);
      mPending = 1'b1;
      mQueued  = 0;
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle", bus.busy, 0);
    mPending = 1'b0;
    mQueued  = 0;
  endtask

  task automatic checkStream();
    wr_t o, e;
    waitIdle();
    repeat (2) @(negedge clk);
    chk("wr count", obsQ.size(), expQ.size());
    lastCycs.delete();
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      o = obsQ.pop_front();
      e = expQ.pop_front();
      chk("wr addr", o.addr, e.addr);
      chk("wr data", o.data, e.data);
      lastCycs.push_back(o.cyc);
    end
    obsQ.delete();
    expQ.delete();
    chk("overflow flag", bus.fifoOverflow, mOvf);
    chk("cmd error flag", bus.cmdError, mCmdErr);
  endtask

  initial begin
    int t1, n, holdBad;
    bus.cpuWriteEnable = 1'b0;
    bus.cpuWriteAddr   = '0;
    bus.cpuWriteData   = '0;
    for (int i = 0; i < 65536; i++) ram[i] = 16'($urandom);
    ram[16'h2000] = 16'h0011;
    ram[16'h2001] = 16'h0022;
    ram[16'h2002] = 16'h0033;

    repeat (3) @(negedge clk);
    chk("reset outs", {bus.nameTableWriteEnable, bus.nameTableWriteAddr, bus.nameTableWriteData,
                       bus.dmaReadReq, bus.busy, bus.fifoOverflow, bus.cmdError}, 0);
    chk("reset raddr", bus.dmaReadAddr, 0);
    rstN = 1'b1;
    @(negedge clk);

    // Two back-to-back bytes: first write lands two cycles after its strobe.
    opPtr(13'h010);
    t1 = cyc;
    opByte(8'h41);
    opByte(8'h42);
    checkStream();
    if (lastCycs.size() >= 2) begin
      chk("latency b1", 32'(lastCycs[0] - t1), 2);
      chk("latency b2", 32'(lastCycs[1] - t1), 3);
    end

    opPtr(13'h1FFF);
    opByte(8'h55);
    opByte(8'h66);
    checkStream();

    grantMode = 1;
    opPtr(13'h100);
    opSrc(16'h2000);
    opLen(13'd3, 3'b000);
    opByte(8'h77);
    checkStream();
    if (lastCycs.size() >= 3) begin
      chk("dma spacing 1", 32'(lastCycs[1] - lastCycs[0]), 2);
      chk("dma spacing 2", 32'(lastCycs[2] - lastCycs[1]), 2);
    end

    reqCount = 0;
    opLen(13'd0, 3'b111);
    repeat (5) @(negedge clk);
    chk("len0 req", reqCount, 0);
    chk("len0 busy", bus.busy, 0);
    checkStream();

    // Stalled DMA: request held, bytes pile up, one is dropped, a second start is rejected.
    grantMode = 0;
    opSrc(16'h3000);
    opLen(13'd2, 3'b000);
    repeat (2) @(negedge clk);
    holdBad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!bus.dmaReadReq || bus.dmaReadAddr != 16'h3000 || bus.nameTableWriteEnable) holdBad++;
      if (i < 5) opByte(8'hA0 + 8'(i));
      else       @(negedge clk);
    end
    opLen(13'd1, 3'b010);
    chk("stall req hold", holdBad, 0);
    chk("stall overflow", bus.fifoOverflow, mOvf);
    chk("stall cmd error", bus.cmdError, mCmdErr);
    grantMode = 1;
    checkStream();

    // Reset in the middle of a transfer.
    cpuWr(NT_DMA_LEN, 16'h0003);
    n = 0;
    while (!bus.dmaReadReq && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("xfer req seen", bus.dmaReadReq, 1);
    @(negedge clk);
    #1 rstN = 1'b0;
    #1;
    chk("async rst outs", {bus.nameTableWriteEnable, bus.nameTableWriteAddr, bus.nameTableWriteData,
                           bus.dmaReadReq, bus.busy, bus.fifoOverflow, bus.cmdError}, 0);
    chk("async rst raddr", bus.dmaReadAddr, 0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    mPtr = '0; mSrc = '0; mOvf = 1'b0; mCmdErr = 1'b0; mPending = 1'b0; mQueued = 0;
    obsQ.delete();
    expQ.delete();
    reqCount = 0;
    repeat (10) @(negedge clk);
    chk("post rst writes", obsQ.size(), 0);
    chk("post rst req", reqCount, 0);
    opByte(8'h3C);
    checkStream();

    grantMode = 2;
    for (int it = 0; it < 80; it++) begin
      int op, nb;
      op = $urandom_range(0, 9);
      case (op)
        0: opPtr(13'($urandom));
        1, 2, 3, 4: begin
          nb = $urandom_range(1, 6);
          for (int k = 0; k < nb; k++) opByte(8'($urandom));
        end
        5: opSrc(16'($urandom));
        6, 7: begin
          waitIdle();
          opLen(13'($urandom_range(0, 5)), 3'($urandom));
          nb = $urandom_range(0, 4);
          for (int k = 0; k < nb; k++) opByte(8'($urandom));
          waitIdle();
        end
        8: cpuWr(16'($urandom_range(0, 16'hFFFC)), 16'($urandom));
        default: repeat ($urandom_range(1, 4)) @(negedge clk);
      endcase
      if (it % 20 == 19) checkStream();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
